niosiisystem_mem_tester: RTL and testbench

//  Avalon-MM master that drives the on-chip SRAM slave (32-bit data, byte-enabled, word-addressed).

---
 rtl/niosiisystem_mem_tester_pkg.sv | 21 ++
 rtl/niosiisystem_mem_tester_patgen.sv | 40 ++++
 rtl/niosiisystem_mem_tester.sv | 156 +++++++++++++++
 tb/tb_niosiisystem_mem_tester.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/niosiisystem_mem_tester_pkg.sv
// Shared types and constants for the Avalon-MM memory self-tester.
// Latency: n/a (types only). Backpressure: n/a.
package niosiisystem_mem_tester_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [15:0] ERR_SAT   = 16'hFFFF;

    // Right-shifting Galois LFSR: feedback taps are XORed in when the output bit is 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/niosiisystem_mem_tester_patgen.sv
// Test-pattern generator: seed+i counter, or Galois LFSR when MEM_TESTER_LFSR_EN is defined.
// Latency: data valid the cycle after load; advances one word per step.
// Backpressure: none; the caller only pulses step when a word is consumed.
module niosiisystem_mem_tester_patgen
    import niosiisystem_mem_tester_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] data
);

    logic [31:0] data_q;
    logic [31:0] load_val;
    logic [31:0] step_val;

`ifdef MEM_TESTER_LFSR_EN
    // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
    assign load_val = (seed == 32'd0) ? 32'd1 : seed;
    assign step_val = lfsr_next(data_q);
`else
    assign load_val = seed;
    assign step_val = data_q + 32'd1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_val;
        end else if (step) begin
            data_q <= step_val;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/niosiisystem_mem_tester.sv
// Avalon-MM SRAM self-tester: write pattern, pipelined read-back, compare. Pattern per MEM_TESTER_LFSR_EN.
// Latency: first write one cycle after start; done the cycle after the final compare.
// Backpressure: requests held stable under waitrequest; reads throttled at MAX_PEND outstanding.
module niosiisystem_mem_tester
    import niosiisystem_mem_tester_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int MAX_PEND = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);

    localparam logic [3:0] PEND_MAX = 4'(MAX_PEND);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issue_idx_q;
    logic [ADDR_W-1:0] cmp_idx_q;
    logic [3:0]        pending_q, pending_d;
    logic [15:0]       err_q;
    logic [ADDR_W-1:0] first_err_q;

    logic              start_ok;
    logic              wr_req, rd_req;
    logic              wr_acc, rd_acc, rsp_vld;
    logic              last_issue, mismatch;
    logic [ADDR_W-1:0] issue_addr, cmp_addr;
    logic [31:0]       wr_pat, exp_pat;

    assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_issue = (issue_idx_q == (len_q - 1'b1));
    assign issue_addr = base_q + issue_idx_q[ADDR_W-1:0];
    assign cmp_addr   = base_q + cmp_idx_q;

    assign wr_req  = (state_q == WRITE);
    assign rd_req  = (state_q == READ) && (pending_q != PEND_MAX);
    assign wr_acc  = wr_req && !avm_waitrequest;
    assign rd_acc  = rd_req && !avm_waitrequest;
    // A response with nothing outstanding is spurious and must not disturb the compare side.
    assign rsp_vld = avm_readdatavalid && (pending_q != 4'd0);
    assign mismatch = (avm_readdata != exp_pat);

    always_comb begin
        pending_d = pending_q;
        if (rd_acc && !rsp_vld) begin
            pending_d = pending_q + 4'd1;
        end else if (!rd_acc && rsp_vld) begin
            pending_d = pending_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (length == '0) ? DONE : WRITE;
                end
            end
            WRITE: if (wr_acc && last_issue) state_d = READ;
            READ:  if (rd_acc && last_issue) state_d = DRAIN;
            DRAIN: if (pending_d == 4'd0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issue_idx_q <= '0;
            cmp_idx_q   <= '0;
            pending_q   <= '0;
            err_q       <= '0;
            first_err_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (start_ok) begin
                base_q      <= base_addr;
                len_q       <= length;
                issue_idx_q <= '0;
                cmp_idx_q   <= '0;
                err_q       <= '0;
                first_err_q <= '0;
            end else begin
                // The write pass rewinds the index so the read pass covers the same words.
                if (wr_acc) begin
                    issue_idx_q <= last_issue ? '0 : issue_idx_q + 1'b1;
                end else if (rd_acc) begin
                    issue_idx_q <= issue_idx_q + 1'b1;
                end
                if (rsp_vld) begin
                    cmp_idx_q <= cmp_idx_q + 1'b1;
                    if (mismatch) begin
                        if (err_q != ERR_SAT) err_q <= err_q + 16'd1;
                        if (err_q == 16'd0)   first_err_q <= cmp_addr;
                    end
                end
            end
        end
    end

    niosiisystem_mem_tester_patgen u_issue_pat (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_ok),
        .step    (wr_acc),
        .seed    (seed),
        .data    (wr_pat)
    );

    niosiisystem_mem_tester_patgen u_cmp_pat (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_ok),
        .step    (rsp_vld),
        .seed    (seed),
        .data    (exp_pat)
    );

    assign busy           = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == 16'd0);
    assign err_count      = err_q;
    assign first_err_addr = first_err_q;

    assign avm_write      = wr_req;
    assign avm_read       = rd_req;
    assign avm_chipselect = wr_req || rd_req;
    assign avm_byteenable = 4'hF;
    assign avm_address    = (wr_req || rd_req) ? issue_addr : '0;
    assign avm_writedata  = wr_req ? wr_pat : 32'd0;

endmodule

// File: tb/tb_niosiisystem_mem_tester.sv
// Directed bench for the memory self-tester with a behavioural Avalon-MM SRAM slave.
module tb_niosiisystem_mem_tester;

    localparam int ADDR_W   = 10;
    localparam int MAX_PEND = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [31:0]       seed;
    logic              busy, done, pass;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect, avm_write, avm_read;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;

    niosiisystem_mem_tester #(.ADDR_W(ADDR_W), .MAX_PEND(MAX_PEND)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .length            (length),
        .seed              (seed),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .err_count         (err_count),
        .first_err_addr    (first_err_addr),
        .avm_address       (avm_address),
        .avm_byteenable    (avm_byteenable),
        .avm_chipselect    (avm_chipselect),
        .avm_write         (avm_write),
        .avm_read          (avm_read),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int limit);
        n_checks++;
        if (act > limit) begin
            n_errors++;
            $display("FAIL %s: got %0d expected <= %0d", name, act, limit);
        end
    endtask

    function automatic logic [31:0] model_pat(input logic [31:0] sd, input int idx);
        logic [31:0] s;
`ifdef MEM_TESTER_LFSR_EN
        s = (sd == 32'd0) ? 32'd1 : sd;
        for (int k = 0; k < idx; k++) begin
            s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
        end
`else
        s = sd + 32'(idx);
`endif
        return s;
    endfunction

    // ---------------- behavioural SRAM slave ----------------
    typedef struct {
        int          due;
        logic [31:0] dat;
    } rsp_t;

    logic [31:0] mem [0:1023];
    rsp_t        rq[$];
    int          cyc = 0;
    int          cur_base, cur_flip, cur_lat;
    logic [31:0] cur_seed;
    bit          cur_rand;
    int          wr_i, rd_i, addr_err, data_err, stall_viol, cs_viol, outstanding, max_out, bus_act;
    bit          stalled;
    logic        s_w, s_r;
    logic [9:0]  s_a;
    logic [31:0] s_d;

    initial begin
        rsp_t r;
        logic wr;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        stalled = 1'b0;
        outstanding = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                rq.delete();
                outstanding       = 0;
                stalled           = 1'b0;
                avm_waitrequest   = 1'b0;
                avm_readdatavalid = 1'b0;
                continue;
            end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = rq[0].dat;
                void'(rq.pop_front());
                outstanding--;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = 32'd0;
            end
            if (stalled && (avm_write !== s_w || avm_read !== s_r ||
                            avm_address !== s_a || avm_writedata !== s_d)) stall_viol++;
            if (avm_chipselect !== (avm_write | avm_read)) cs_viol++;
            wr = cur_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            if (avm_write || avm_read) begin
                bus_act++;
                stalled = wr;
                s_w = avm_write; s_r = avm_read; s_a = avm_address; s_d = avm_writedata;
                if (!wr && avm_write) begin
                    if (int'(avm_address) != ((cur_base + wr_i) % 1024)) addr_err++;
                    if (avm_writedata !== model_pat(cur_seed, wr_i)) data_err++;
                    mem[avm_address] = avm_writedata;
                    wr_i++;
                end else if (!wr && avm_read) begin
                    if (int'(avm_address) != ((cur_base + rd_i) % 1024)) addr_err++;
                    r.due = cyc + cur_lat;
                    r.dat = mem[avm_address] ^ ((int'(avm_address) == cur_flip) ? 32'd1 : 32'd0);
                    rq.push_back(r);
                    rd_i++;
                    outstanding++;
                    if (outstanding > max_out) max_out = outstanding;
                end
            end else begin
                stalled = 1'b0;
            end
            avm_waitrequest = wr;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [9:0]  base;
        logic [10:0] len;
        logic [31:0] seed;
        bit          rand_wait;
        int          lat;
        int          flip;
        int          max_cyc;
        logic [15:0] exp_err;
        logic [9:0]  exp_first;
        logic        exp_pass;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int id);
        int k;
        cur_base = int'(v.base); cur_seed = v.seed; cur_flip = v.flip;
        cur_lat = v.lat; cur_rand = v.rand_wait;
        wr_i = 0; rd_i = 0; addr_err = 0; data_err = 0; stall_viol = 0;
        cs_viol = 0; max_out = 0;
        @(negedge clk);
        base_addr = v.base; length = v.len; seed = v.seed; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d busy_n+1", id), 64'(busy), 64'd1);
        check($sformatf("v%0d write_n+1", id), 64'(avm_write), 64'd1);
        k = 1;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_le($sformatf("v%0d start_to_done", id), k, v.max_cyc);
        check($sformatf("v%0d err_count", id), 64'(err_count), 64'(v.exp_err));
        check($sformatf("v%0d first_err_addr", id), 64'(first_err_addr), 64'(v.exp_first));
        check($sformatf("v%0d pass", id), 64'(pass), 64'(v.exp_pass));
        check($sformatf("v%0d busy_at_done", id), 64'(busy), 64'd0);
        check($sformatf("v%0d writes", id), 64'(wr_i), 64'(v.len));
        check($sformatf("v%0d reads", id), 64'(rd_i), 64'(v.len));
        check($sformatf("v%0d addr_errs", id), 64'(addr_err), 64'd0);
        check($sformatf("v%0d wdata_errs", id), 64'(data_err), 64'd0);
        check($sformatf("v%0d stall_viol", id), 64'(stall_viol), 64'd0);
        check($sformatf("v%0d chipselect_viol", id), 64'(cs_viol), 64'd0);
        check_le($sformatf("v%0d max_outstanding", id), max_out, MAX_PEND);
    endtask

    initial begin
        //          base     len     seed          rnd   lat flip  maxc err    first   pass
        vecs[0] = '{10'd0,   11'd16, 32'hA5A50000, 1'b0, 1, -1,  36,  16'd0, 10'd0,   1'b1};
        vecs[1] = '{10'd0,   11'd16, 32'hA5A50000, 1'b1, 1, -1,  300, 16'd0, 10'd0,   1'b1};
        vecs[2] = '{10'd0,   11'd16, 32'hA5A50000, 1'b0, 1, 5,   36,  16'd1, 10'd5,   1'b0};
        vecs[3] = '{10'd1020, 11'd8, 32'h12345678, 1'b0, 1, -1,  20,  16'd0, 10'd0,   1'b1};
        vecs[4] = '{10'd100, 11'd12, 32'hDEADBEEF, 1'b0, 6, -1,  80,  16'd0, 10'd0,   1'b1};
        vecs[5] = '{10'd200, 11'd10, 32'h00000000, 1'b1, 2, 203, 200, 16'd1, 10'd203, 1'b0};

        cur_base = 0; cur_seed = 0; cur_flip = -1; cur_lat = 1; cur_rand = 1'b0;
        wr_i = 0; rd_i = 0; addr_err = 0; data_err = 0; stall_viol = 0;
        cs_viol = 0; max_out = 0; bus_act = 0;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; seed = '0;

        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst pass", 64'(pass), 64'd0);
        check("rst err_count", 64'(err_count), 64'd0);
        check("rst first_err_addr", 64'(first_err_addr), 64'd0);
        check("rst avm_address", 64'(avm_address), 64'd0);
        check("rst avm_byteenable", 64'(avm_byteenable), 64'hF);
        check("rst avm_chipselect", 64'(avm_chipselect), 64'd0);
        check("rst avm_write", 64'(avm_write), 64'd0);
        check("rst avm_read", 64'(avm_read), 64'd0);
        check("rst avm_writedata", 64'(avm_writedata), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Zero length from DONE with errors: clears the result and issues no bus cycles.
        bus_act = 0;
        cur_rand = 1'b0;
        base_addr = 10'd5; length = '0; seed = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("len0 done", 64'(done), 64'd1);
        check("len0 pass", 64'(pass), 64'd1);
        check("len0 err_count", 64'(err_count), 64'd0);
        check("len0 first_err_addr", 64'(first_err_addr), 64'd0);
        check("len0 busy", 64'(busy), 64'd0);
        check("len0 bus_activity", 64'(bus_act), 64'd0);

        // Reset in the middle of the write pass drops requests without a clock edge.
        cur_base = 0; cur_seed = 32'd1; cur_flip = -1; wr_i = 0; rd_i = 0;
        base_addr = '0; length = 11'd16; seed = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst pre write", 64'(avm_write), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst avm_write", 64'(avm_write), 64'd0);
        check("midrst avm_read", 64'(avm_read), 64'd0);
        check("midrst avm_chipselect", 64'(avm_chipselect), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(vecs[0], 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
